// File: rtl/rvbridge_decode.sv
// rvbridge_decode: Avalon-ST Video (VIP) to raw pixel stream bridge; latches control-packet geometry.
// Define RVBRIDGE_DECODE_SIZE_CHECK_EN to add the data-packet pixel count check on size_err.
module rvbridge_decode #(
   parameter int DATA_BITS   = 8,
   parameter int DATA_PLANES = 3,
   parameter int DATA_WIDTH  = DATA_BITS * DATA_PLANES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] din_data,
   input  logic                  din_valid,
   input  logic                  din_startofpacket,
   input  logic                  din_endofpacket,
   output logic                  din_ready,
   output logic [DATA_WIDTH-1:0] dout_data,
   output logic                  dout_valid,
   output logic                  dout_startofpacket,
   output logic                  dout_endofpacket,
   input  logic                  dout_ready,
   output logic [15:0]           video_width,
   output logic [15:0]           video_height,
   output logic [3:0]            video_interlaced,
   output logic                  ctrl_update,
   output logic                  size_err
);
   localparam int REQ_BEATS = (9 + DATA_PLANES - 1) / DATA_PLANES;
   typedef enum logic [1:0] {IDLE, CTRL, DATA, SKIP} state_t;
   state_t state, state_nx;
   logic xfer, sop, eop, ctrl_beat, ctrl_done, first_pix;
   logic [3:0] beat_cnt;
   logic [3:0] nib [9];
   logic [3:0] nib_nx [9];
   assign xfer      = din_valid && din_ready;
   assign sop       = xfer && din_startofpacket;
   assign eop       = xfer && din_endofpacket && !din_startofpacket;
   assign ctrl_beat = state == CTRL && xfer && !din_startofpacket;
   assign ctrl_done = ctrl_beat && din_endofpacket && int'(beat_cnt) + 1 >= REQ_BEATS;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   always_comb begin
      state_nx = state;
      if (sop)
         state_nx = din_endofpacket ? IDLE : din_data[3:0] == 4'hF ? CTRL : din_data[3:0] == 4'h0 ? DATA : SKIP;
      else if (eop)
         state_nx = IDLE;
   end
   always_comb begin
      din_ready          = state == DATA ? dout_ready : 1'b1;
      dout_data          = din_data;
      dout_valid         = state == DATA && din_valid;
      dout_startofpacket = first_pix && dout_valid;
      dout_endofpacket   = din_endofpacket && dout_valid;
   end
   // Control beat k lands nibble plane i at slot DATA_PLANES*k+i; slots past the interlace nibble are dropped.
   always_comb begin
      nib_nx = nib;
      for (int j = 0; j < 9; j++)
         for (int i = 0; i < DATA_PLANES; i++)
            if (ctrl_beat && DATA_PLANES * int'(beat_cnt) + i == j)
               nib_nx[j] = din_data[DATA_BITS*i +: 4];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         beat_cnt         <= '0;
         first_pix        <= 1'b0;
         nib              <= '{default: '0};
         ctrl_update      <= 1'b0;
         video_width      <= '0;
         video_height     <= '0;
         video_interlaced <= '0;
      end else begin
         beat_cnt    <= sop ? 4'd0 : ctrl_beat && beat_cnt != 4'hF ? beat_cnt + 4'd1 : beat_cnt;
         first_pix   <= sop ? state_nx == DATA : state == DATA && xfer ? 1'b0 : first_pix;
         nib         <= nib_nx;
         ctrl_update <= ctrl_done;
         if (ctrl_done) begin
            video_width      <= {nib_nx[0], nib_nx[1], nib_nx[2], nib_nx[3]};
            video_height     <= {nib_nx[4], nib_nx[5], nib_nx[6], nib_nx[7]};
            video_interlaced <= nib_nx[8];
         end
      end
`ifdef RVBRIDGE_DECODE_SIZE_CHECK_EN
   logic [31:0] pix_cnt, frame_area;
   assign frame_area = 32'(video_width) * 32'(video_height);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pix_cnt  <= '0;
         size_err <= 1'b0;
      end else begin
         pix_cnt  <= sop ? 32'd0 : state == DATA && xfer ? pix_cnt + 32'd1 : pix_cnt;
         size_err <= state == DATA && eop && pix_cnt + 32'd1 != frame_area;
      end
`else
   assign size_err = 1'b0;
`endif
endmodule
